cv32e40p_tmr_fault_mgr: RTL and testbench
=========================================

Name: cv32e40p_tmr_fault_mgr

Overview:
- Sits directly downstream of the triplicated multiplier's majority voters and consumes their per-output mismatch flags.
- Turns raw mismatch flags into three things:
  - architectural fault status (sticky per-source bits plus a saturating event counter);
  - a bounded replay request to the EX stage on a transient fault;
  - a latched permanent-fault alarm after repeated consecutive faults.
- Single clock domain; all outputs registered.

Parameters:
- NUM_SRC, 4, number of voter mismatch flags (bit 0 result, 1 multicycle, 2 mulh_active, 3 ready).
- CNT_W, 8, width of the saturating total fault counter.
- PERM_THRESH, 3, consecutive faulty samples that declare a permanent fault; legal range 1..15.
- REPLAY_CYCLES, 2, cycles replay_req_o and stall_o stay high per transient fault; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- fault_src_i  input  NUM_SRC  voter detected flags, combinational from the voters.
- sample_i  input  1  multiplier output is consumed this cycle (ex_ready_i & mult ready); qualifies fault_src_i.
- clear_i  input  1  software/debug clear of all status.
- sticky_o  output  NUM_SRC  OR-accumulated faulty sources since the last clear.
- fault_cnt_o  output  CNT_W  total accepted fault events, saturating.
- replay_req_o  output  1  EX must re-issue the current multiply.
- stall_o  output  1  hold EX/WB writeback of the multiplier result.
- perm_fault_o  output  1  permanent fault latched.
- irq_o  output  1  one-cycle pulse per accepted fault event.

Behaviour:
- Reset (async assert, sync release): state MONITOR; sticky_o, fault_cnt_o, consecutive counter, replay timer all 0; replay_req_o, stall_o, perm_fault_o, irq_o all 0.
- Accepted event: fault_evt = sample_i & |fault_src_i & (state == MONITOR) & ~clear_i. Events in REPLAY or ALARM are ignored; the replayed operation is sampled again after return to MONITOR.
- Latency: event at edge t → sticky, count, irq_o and state outputs visible after edge t+1. No combinational input→output paths.
- MONITOR:
  - On fault_evt: sticky_o |= fault_src_i; fault_cnt_o +1, saturating at 2^CNT_W-1; consec +1; irq_o=1 for one cycle.
  - If consec+1 >= PERM_THRESH → ALARM; otherwise → REPLAY with timer = REPLAY_CYCLES.
  - On sample_i & ~|fault_src_i: consec cleared to 0.
  - No sample_i: consec held.
- REPLAY:
  - replay_req_o=1 and stall_o=1 in every REPLAY cycle.
  - Timer decrements each cycle; leaving at timer==1 → MONITOR, so outputs are high for exactly REPLAY_CYCLES cycles.
  - consec is held.
- ALARM:
  - perm_fault_o=1 and stall_o=1, held indefinitely; replay_req_o=0.
  - Only clear_i or rst exits.
- clear_i, any state: next cycle is MONITOR with sticky, fault_cnt, consec, timer = 0 and all flag outputs 0.
  - clear_i beats a same-cycle fault_evt; the event is dropped, with no irq and no count.
- PERM_THRESH=1: the first fault goes straight to ALARM and REPLAY is never entered.
- fault_src_i with several bits set counts as one event; all set bits are OR-ed into sticky.
- Counter at saturation: irq_o still pulses and sticky still updates; the count is held.
- Reset mid-REPLAY or mid-ALARM: immediate return to reset values; no residual replay cycle after release.

Decomposition:
- Shared package cv32e40p_pkg gets:
  - typedef enum logic [1:0] fault_mgr_state_e {FM_MONITOR, FM_REPLAY, FM_ALARM};
  - constants FM_SRC_RESULT=0, FM_SRC_MCYCLE=1, FM_SRC_MULH=2, FM_SRC_READY=3.
- One sub-module, cv32e40p_sat_counter (parameter W; inc, clr; saturating; async active-high reset). It is used for fault_cnt and is reusable for other TMR'd units.
- consec counter and replay timer are kept inline.

Test Plan:
- Transient fault: fault_src_i=4'b0001 with sample_i for 1 cycle, defaults → irq_o pulse next cycle; sticky_o=0001; fault_cnt_o=1; replay_req_o and stall_o high exactly 2 cycles; then MONITOR with perm_fault_o=0.
- Consecutive faults: three faulty samples, each taken after the preceding REPLAY ends, with no clean sample between → 2 REPLAY episodes, then perm_fault_o=1, stall_o=1, fault_cnt_o=3. A clean sample between the 2nd and 3rd fault resets consec, so no ALARM.
- Multi-source event: fault_src_i=4'b1010 → sticky_o=1010, fault_cnt_o +1 (not +2); fault_src_i=1111 with sample_i=0 → no change.
- Clear vs fault: clear_i and a faulty sample in the same cycle while in ALARM → next cycle all outputs 0, fault_cnt_o=0, irq_o=0.
- Saturation: CNT_W=2, five separated transient faults → fault_cnt_o sequence 1,2,3,3,3 with five irq_o pulses.
- Async reset: assert rst mid-REPLAY between edges → replay_req_o and stall_o drop immediately (no clock edge required); after release, no replay cycles resume.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the TMR multiplier fault-management slice.
package cv32e40p_pkg;

  // Fault manager operating modes
  typedef enum logic [1:0] {
    FM_MONITOR = 2'b00,
    FM_REPLAY  = 2'b01,
    FM_ALARM   = 2'b10
  } fault_mgr_state_e;

  // Bit positions of the voter mismatch flags in fault_src_i
  localparam int unsigned FM_SRC_RESULT = 32'd0;
  localparam int unsigned FM_SRC_MCYCLE = 32'd1;
  localparam int unsigned FM_SRC_MULH   = 32'd2;
  localparam int unsigned FM_SRC_READY  = 32'd3;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Intended for any TMR'd unit that needs a bounded event count (W >= 2).
module cv32e40p_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

  // Count register: clear wins over increment, increment stops at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_ZERO;
    end else if (clr) begin
      cnt <= CNT_ZERO;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_mgr.sv
// Fault manager behind the triplicated multiplier's voters: sticky status,
// saturating event count, bounded replay on transient faults and a latched
// permanent-fault alarm after repeated consecutive faulty samples.
module cv32e40p_tmr_fault_mgr
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned PERM_THRESH   = 3,
  parameter int unsigned REPLAY_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] fault_src_i,
  input  logic               sample_i,
  input  logic               clear_i,
  output logic [NUM_SRC-1:0] sticky_o,
  output logic [CNT_W-1:0]   fault_cnt_o,
  output logic               replay_req_o,
  output logic               stall_o,
  output logic               perm_fault_o,
  output logic               irq_o
);

  localparam logic [4:0] THRESH_C = 5'(PERM_THRESH);
  localparam logic [3:0] REPLAY_C = 4'(REPLAY_CYCLES);

  fault_mgr_state_e   state_r;
  fault_mgr_state_e   state_nxt_s;
  logic [3:0]         consec_r;
  logic [3:0]         consec_nxt_s;
  logic [3:0]         timer_r;
  logic [3:0]         timer_nxt_s;
  logic [NUM_SRC-1:0] sticky_r;
  logic [NUM_SRC-1:0] sticky_nxt_s;
  logic [4:0]         consec_inc_s;
  logic               fault_evt_s;
  logic               irq_r;
  logic               replay_req_r;
  logic               stall_r;
  logic               perm_fault_r;

  // Accepted event: qualified sample, any flag set, only while monitoring, and
  // a same-cycle clear drops it
  always_comb begin
    fault_evt_s  = sample_i & (|fault_src_i) & (state_r == FM_MONITOR) & ~clear_i;
    consec_inc_s = {1'b0, consec_r} + 5'd1;
  end

  // Next-state, sticky, consecutive-fault and replay-timer logic
  always_comb begin
    state_nxt_s  = state_r;
    consec_nxt_s = consec_r;
    timer_nxt_s  = timer_r;
    sticky_nxt_s = sticky_r;
    if (clear_i) begin
      state_nxt_s  = FM_MONITOR;
      consec_nxt_s = 4'd0;
      timer_nxt_s  = 4'd0;
      sticky_nxt_s = {NUM_SRC{1'b0}};
    end else begin
      case (state_r)
        FM_MONITOR: begin
          if (fault_evt_s) begin
            sticky_nxt_s = sticky_r | fault_src_i;
            consec_nxt_s = consec_inc_s[3:0];
            if (consec_inc_s >= THRESH_C) begin
              state_nxt_s = FM_ALARM;
              timer_nxt_s = 4'd0;
            end else begin
              state_nxt_s = FM_REPLAY;
              timer_nxt_s = REPLAY_C;
            end
          end else if (sample_i) begin
            // A clean sample breaks the run of consecutive faults
            consec_nxt_s = 4'd0;
          end else begin
            consec_nxt_s = consec_r;
          end
        end
        FM_REPLAY: begin
          if (timer_r <= 4'd1) begin
            state_nxt_s = FM_MONITOR;
            timer_nxt_s = 4'd0;
          end else begin
            timer_nxt_s = timer_r - 4'd1;
          end
        end
        FM_ALARM: begin
          state_nxt_s = FM_ALARM;
        end
        default: begin
          // Unreachable encoding: fall back to monitoring with a clean timer
          state_nxt_s = FM_MONITOR;
          timer_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State and status registers; flag outputs are derived from the next state
  // so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FM_MONITOR;
      consec_r     <= 4'd0;
      timer_r      <= 4'd0;
      sticky_r     <= {NUM_SRC{1'b0}};
      irq_r        <= 1'b0;
      replay_req_r <= 1'b0;
      stall_r      <= 1'b0;
      perm_fault_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      consec_r     <= consec_nxt_s;
      timer_r      <= timer_nxt_s;
      sticky_r     <= sticky_nxt_s;
      irq_r        <= fault_evt_s;
      replay_req_r <= (state_nxt_s == FM_REPLAY);
      stall_r      <= (state_nxt_s == FM_REPLAY) || (state_nxt_s == FM_ALARM);
      perm_fault_r <= (state_nxt_s == FM_ALARM);
    end
  end

  cv32e40p_sat_counter #(
    .W (CNT_W)
  ) u_fault_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fault_evt_s),
    .clr (clear_i),
    .cnt (fault_cnt_o)
  );

  assign sticky_o     = sticky_r;
  assign irq_o        = irq_r;
  assign replay_req_o = replay_req_r;
  assign stall_o      = stall_r;
  assign perm_fault_o = perm_fault_r;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_mgr.sv
// Bench for cv32e40p_tmr_fault_mgr: directed scenarios plus random traffic,
// checked against an event-level reference model. A second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_cv32e40p_tmr_fault_mgr;
  import cv32e40p_pkg::*;

  localparam int PT      = 3;
  localparam int RC      = 2;
  localparam int CNT_MAX = 255;
  localparam int SAT_MAX = 3;

  logic       clk;
  logic       rst;
  logic [3:0] fault_src_i;
  logic       sample_i;
  logic       clear_i;

  logic [3:0] sticky_o;
  logic [7:0] fault_cnt_o;
  logic       replay_req_o, stall_o, perm_fault_o, irq_o;

  logic [3:0] s_sticky;
  logic [1:0] s_cnt;
  logic       s_replay, s_stall, s_perm, s_irq;

  cv32e40p_tmr_fault_mgr #(
    .NUM_SRC(4), .CNT_W(8), .PERM_THRESH(PT), .REPLAY_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .fault_src_i(fault_src_i), .sample_i(sample_i),
    .clear_i(clear_i), .sticky_o(sticky_o), .fault_cnt_o(fault_cnt_o),
    .replay_req_o(replay_req_o), .stall_o(stall_o),
    .perm_fault_o(perm_fault_o), .irq_o(irq_o)
  );

  cv32e40p_tmr_fault_mgr #(
    .NUM_SRC(4), .CNT_W(2), .PERM_THRESH(PT), .REPLAY_CYCLES(RC)
  ) dut_sat (
    .clk(clk), .rst(rst), .fault_src_i(fault_src_i), .sample_i(sample_i),
    .clear_i(clear_i), .sticky_o(s_sticky), .fault_cnt_o(s_cnt),
    .replay_req_o(s_replay), .stall_o(s_stall),
    .perm_fault_o(s_perm), .irq_o(s_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: "alarmed" flag, remaining replay cycles, run length of
  // consecutive faulty samples, accumulated sources and an unbounded count
  bit         m_alarm;
  int         m_rleft;
  int         m_consec;
  logic [3:0] m_sticky;
  int         m_cnt;
  bit         m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int cap(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_alarm = 1'b0; m_rleft = 0; m_consec = 0;
    m_sticky = 4'd0; m_cnt = 0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [3:0] src, input logic c);
    bit idle;
    m_irq = 1'b0;
    if (c) begin
      model_reset();
    end else begin
      idle = !m_alarm && (m_rleft == 0);
      if (m_rleft > 0) m_rleft--;
      if (idle && s && (src != 4'd0)) begin
        m_irq = 1'b1;
        m_sticky = m_sticky | src;
        m_cnt++;
        m_consec++;
        if (m_consec >= PT) m_alarm = 1'b1;
        else m_rleft = RC;
      end else if (idle && s) begin
        m_consec = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("sticky",   sticky_o,     m_sticky);
    check("cnt",      fault_cnt_o,  cap(m_cnt, CNT_MAX));
    check("replay",   replay_req_o, (m_rleft > 0));
    check("stall",    stall_o,      (m_rleft > 0) || m_alarm);
    check("perm",     perm_fault_o, m_alarm);
    check("irq",      irq_o,        m_irq);
    check("sat_cnt",  s_cnt,        cap(m_cnt, SAT_MAX));
    check("sat_irq",  s_irq,        m_irq);
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare after it
  task automatic tick(input logic s, input logic [3:0] src, input logic c);
    sample_i = s; fault_src_i = src; clear_i = c;
    @(posedge clk);
    model_step(s, src, c);
    #1;
    compare_all();
    sample_i = 1'b0; fault_src_i = 4'd0; clear_i = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 4'd0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must drop without a clock edge
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] src_r;
  logic [3:0] src_m;
  int         irq_seen;
  int         rv;

  initial begin
    rst = 1'b1; sample_i = 1'b0; fault_src_i = 4'd0; clear_i = 1'b0;
    src_r = 4'd1 << FM_SRC_RESULT;
    src_m = (4'd1 << FM_SRC_MCYCLE) | (4'd1 << FM_SRC_READY);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Transient fault: one irq, two replay cycles, back to monitoring
    tick(1'b1, src_r, 1'b0);
    check("tr_irq", irq_o, 1'b1);
    check("tr_sticky", sticky_o, 4'b0001);
    check("tr_cnt", fault_cnt_o, 8'd1);
    check("tr_replay1", replay_req_o, 1'b1);
    tick(1'b0, 4'd0, 1'b0);
    check("tr_replay2", replay_req_o, 1'b1);
    tick(1'b0, 4'd0, 1'b0);
    check("tr_replay_end", replay_req_o, 1'b0);
    check("tr_no_perm", perm_fault_o, 1'b0);

    // Three consecutive faulty samples escalate to the alarm
    tick(1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, src_r, 1'b0);
      if (i < 2) idle_n(RC);
    end
    check("cons_perm", perm_fault_o, 1'b1);
    check("cons_stall", stall_o, 1'b1);
    check("cons_cnt", fault_cnt_o, 8'd3);
    idle_n(3);
    tick(1'b1, src_r, 1'b0);
    check("alarm_ignores", fault_cnt_o, 8'd3);

    // Clear beats a same-cycle faulty sample while alarmed
    tick(1'b1, 4'b1111, 1'b1);
    check("clr_perm", perm_fault_o, 1'b0);
    check("clr_stall", stall_o, 1'b0);
    check("clr_cnt", fault_cnt_o, 8'd0);
    check("clr_irq", irq_o, 1'b0);

    // A clean sample between the 2nd and 3rd fault prevents the alarm
    tick(1'b1, src_r, 1'b0); idle_n(RC);
    tick(1'b1, src_r, 1'b0); idle_n(RC);
    tick(1'b1, 4'd0, 1'b0);
    tick(1'b1, src_r, 1'b0);
    check("clean_no_perm", perm_fault_o, 1'b0);
    check("clean_replay", replay_req_o, 1'b1);
    idle_n(RC);

    // Multi-source event counts once; unsampled flags are ignored
    tick(1'b0, 4'd0, 1'b1);
    tick(1'b1, src_m, 1'b0);
    check("multi_sticky", sticky_o, 4'b1010);
    check("multi_cnt", fault_cnt_o, 8'd1);
    idle_n(RC);
    tick(1'b0, 4'b1111, 1'b0);
    check("nosmp_sticky", sticky_o, 4'b1010);
    check("nosmp_cnt", fault_cnt_o, 8'd1);

    // Saturation on the 2-bit instance: 1,2,3,3,3 with five irq pulses
    tick(1'b0, 4'd0, 1'b1);
    irq_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, src_r, 1'b0);
      if (s_irq) irq_seen++;
      check("sat_seq", s_cnt, cap(i + 1, SAT_MAX));
      idle_n(RC);
      tick(1'b1, 4'd0, 1'b0);
    end
    check("sat_irqs", irq_seen, 5);
    check("sat_wide_cnt", fault_cnt_o, 8'd5);

    // Async reset in the middle of a replay
    tick(1'b1, src_r, 1'b0);
    check("ar_pre_replay", replay_req_o, 1'b1);
    async_reset();
    check("ar_replay", replay_req_o, 1'b0);
    check("ar_stall", stall_o, 1'b0);
    idle_n(3);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rv = $urandom_range(0, 199);
      if (rv == 0) begin
        async_reset();
      end else begin
        tick(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
             ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
